// File: rtl/nco_sweep_controller.sv
// nco_sweep_controller: steps an NCO frequency word from start to stop with per-word dwell,
// in single, sawtooth or triangle mode.
module nco_sweep_controller #(
  parameter int WORD_WIDTH  = 32,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [WORD_WIDTH-1:0]  start_word,
  input  logic [WORD_WIDTH-1:0]  stop_word,
  input  logic [WORD_WIDTH-1:0]  step_word,
  input  logic [DWELL_WIDTH-1:0] dwell_cycles,
  input  logic [1:0]             mode,
  output logic [WORD_WIDTH-1:0]  frequency_word,
  output logic                   nco_enable,
  output logic                   busy,
  output logic                   step_strobe,
  output logic                   sweep_done
);
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
  state_t state, state_n;
  logic [WORD_WIDTH-1:0] s_word, e_word, st_word, freq_n, up_w, dn_w;
  logic [DWELL_WIDTH-1:0] dwell, cnt, cnt_n;
  logic [1:0] mode_r;
  logic [WORD_WIDTH:0] up_sum, dn_diff;
  logic accept, dwell_end, degen, single, strobe_n, done_n;
  assign accept    = state == IDLE && start && !stop;
  assign up_sum    = {1'b0, frequency_word} + {1'b0, st_word};
  assign dn_diff   = {1'b0, frequency_word} - {1'b0, st_word};
  assign up_w      = (up_sum[WORD_WIDTH] || up_sum[WORD_WIDTH-1:0] >= e_word) ? e_word : up_sum[WORD_WIDTH-1:0];
  assign dn_w      = (dn_diff[WORD_WIDTH] || dn_diff[WORD_WIDTH-1:0] <= s_word) ? s_word : dn_diff[WORD_WIDTH-1:0];
  assign dwell_end = dwell <= DWELL_WIDTH'(1) || cnt == dwell - DWELL_WIDTH'(1);
  assign degen     = st_word == '0 || s_word >= e_word;
  assign single    = mode_r[0] == mode_r[1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      frequency_word <= '0;
      cnt            <= '0;
      step_strobe    <= 1'b0;
      sweep_done     <= 1'b0;
      s_word         <= '0;
      e_word         <= '0;
      st_word        <= '0;
      dwell          <= '0;
      mode_r         <= '0;
    end else begin
      state          <= state_n;
      frequency_word <= freq_n;
      cnt            <= cnt_n;
      step_strobe    <= strobe_n;
      sweep_done     <= done_n;
      if (accept) begin
        s_word  <= start_word;
        e_word  <= stop_word;
        st_word <= step_word;
        dwell   <= dwell_cycles;
        mode_r  <= mode;
      end
    end
  end
  // Turnarounds reuse the clamped next-word of the new direction so endpoints dwell once.
  always_comb begin
    state_n  = state;
    freq_n   = frequency_word;
    cnt_n    = cnt + DWELL_WIDTH'(1);
    strobe_n = 1'b0;
    done_n   = 1'b0;
    if (stop) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (state == IDLE) begin
      cnt_n = '0;
      if (start) begin
        state_n  = UP;
        freq_n   = start_word;
        strobe_n = 1'b1;
      end
    end else if (dwell_end) begin
      cnt_n = '0;
      if (degen) begin
        state_n = single ? IDLE : state;
        done_n  = single;
      end else if (state == UP && frequency_word == e_word) begin
        state_n  = single ? IDLE : (mode_r == 2'b10 ? DOWN : UP);
        done_n   = single;
        strobe_n = !single;
        freq_n   = single ? frequency_word : (mode_r == 2'b10 ? dn_w : s_word);
      end else if (state == UP) begin
        freq_n   = up_w;
        strobe_n = 1'b1;
      end else begin
        state_n  = frequency_word == s_word ? UP : DOWN;
        freq_n   = frequency_word == s_word ? up_w : dn_w;
        strobe_n = 1'b1;
      end
    end
  end
  always_comb begin
    busy       = state != IDLE;
    nco_enable = state != IDLE;
  end
endmodule

// File: tb/tb_nco_sweep_controller.sv
// tb_nco_sweep_controller: table-driven sweep scenarios plus hand-written stop, collision,
// busy-start and asynchronous reset sequences.
module tb_nco_sweep_controller;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [31:0] start_word = '0, stop_word = '0, step_word = '0, frequency_word;
  logic [15:0] dwell_cycles = '0;
  logic [1:0]  mode = '0;
  logic        nco_enable, busy, step_strobe, sweep_done;
  int          total = 0, passed = 0;

  nco_sweep_controller dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .start_word(start_word),
    .stop_word(stop_word), .step_word(step_word), .dwell_cycles(dwell_cycles), .mode(mode),
    .frequency_word(frequency_word), .nco_enable(nco_enable), .busy(busy),
    .step_strobe(step_strobe), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sw, ew, stp;
    logic [15:0] dw;
    logic [1:0]  md;
    int          n, done_c, strobes;
  } scen_t;
  typedef logic [31:0] wl_t [16];
  localparam logic [31:0] M1 = 32'h100000, M2 = 32'h200000, M3 = 32'h300000, M4 = 32'h400000;
  scen_t tbl [8];
  wl_t   exp_w [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic go(input logic [31:0] sw, ew, stp, input logic [15:0] dw, input logic [1:0] md);
    @(negedge clk);
    start_word = sw; stop_word = ew; step_word = stp; dwell_cycles = dw; mode = md; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic run_scen(input int i);
    int strobes = 0;
    go(tbl[i].sw, tbl[i].ew, tbl[i].stp, tbl[i].dw, tbl[i].md);
    for (int c = 1; c <= tbl[i].n; c++) begin
      chk($sformatf("s%0d c%0d word", i, c), frequency_word, exp_w[i][c-1]);
      chk($sformatf("s%0d c%0d busy", i, c), {31'd0, busy}, {31'd0, tbl[i].done_c == 0 || c < tbl[i].done_c});
      chk($sformatf("s%0d c%0d done", i, c), {31'd0, sweep_done}, {31'd0, c == tbl[i].done_c});
      if (c == tbl[i].done_c) chk($sformatf("s%0d nco_enable", i), {31'd0, nco_enable}, 32'd0);
      strobes += int'(step_strobe);
      @(negedge clk);
    end
    chk($sformatf("s%0d strobes", i), strobes, tbl[i].strobes);
    halt();
  endtask

  initial begin
    tbl[0] = '{M1, M4, M1, 16'd3, 2'b00, 13, 13, 4};
    exp_w[0] = '{M1, M1, M1, M2, M2, M2, M3, M3, M3, M4, M4, M4, M4, 0, 0, 0};
    tbl[1] = '{32'h0, 32'h250000, M1, 16'd1, 2'b00, 5, 5, 4};
    exp_w[1] = '{0, M1, M2, 32'h250000, 32'h250000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{32'hC0000000, 32'hFFFFFFFF, 32'h80000000, 16'd1, 2'b00, 3, 3, 2};
    exp_w[2] = '{32'hC0000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{32'h10, 32'h30, 32'h10, 16'd0, 2'b10, 10, 0, 10};
    exp_w[3] = '{32'h10, 32'h20, 32'h30, 32'h20, 32'h10, 32'h20, 32'h30, 32'h20, 32'h10, 32'h20, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{32'h10, 32'h30, 32'h10, 16'd0, 2'b01, 10, 0, 10};
    exp_w[4] = '{32'h10, 32'h20, 32'h30, 32'h10, 32'h20, 32'h30, 32'h10, 32'h20, 32'h30, 32'h10, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{32'h55, 32'h100, 32'h0, 16'd2, 2'b00, 3, 3, 1};
    exp_w[5] = '{32'h55, 32'h55, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[6] = '{32'h40, 32'h20, 32'h10, 16'd1, 2'b01, 6, 0, 1};
    exp_w[6] = '{32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[7] = '{32'h10, 32'h30, 32'h10, 16'd2, 2'b11, 7, 7, 3};
    exp_w[7] = '{32'h10, 32'h10, 32'h20, 32'h20, 32'h30, 32'h30, 32'h30, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    #2;
    chk("reset word", frequency_word, 32'h0);
    chk("reset outputs", {28'd0, nco_enable, busy, step_strobe, sweep_done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_scen(i);

    go(M1, M4, M1, 16'd3, 2'b00);
    repeat (4) @(negedge clk);
    chk("stop c5 word", frequency_word, M2);
    halt();
    chk("stop c6 word", frequency_word, M2);
    chk("stop c6 outputs", {28'd0, nco_enable, busy, step_strobe, sweep_done}, 32'h0);

    start_word = 32'h777; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("start+stop word", frequency_word, M2);
    chk("start+stop outputs", {28'd0, nco_enable, busy, step_strobe, sweep_done}, 32'h0);

    go(M1, M4, M1, 16'd3, 2'b00);
    @(negedge clk);
    start = 1'b1; start_word = 32'h999; dwell_cycles = 16'd1; mode = 2'b10;
    @(negedge clk);
    start = 1'b0;
    chk("busy start c3 word", frequency_word, M1);
    chk("busy start c3 strobe", {31'd0, step_strobe}, 32'd0);
    @(negedge clk);
    chk("busy start c4 word", frequency_word, M2);
    chk("busy start c4 strobe", {31'd0, step_strobe}, 32'd1);
    halt();

    go(M1, M4, M1, 16'd1, 2'b00);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst word", frequency_word, 32'h0);
    chk("async rst outputs", {28'd0, nco_enable, busy, step_strobe, sweep_done}, 32'h0);
    #1 rst = 1'b0;
    go(32'h10, 32'h30, 32'h10, 16'd0, 2'b10);
    chk("post rst word", frequency_word, 32'h10);
    chk("post rst outputs", {28'd0, nco_enable, busy, step_strobe, sweep_done}, 32'hE);
    halt();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/nco_sweep_controller.md
NCO_SWEEP_CONTROLLER -- requirements
Module: nco_sweep_controller

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, width of all frequency words (matches NCO frequency_word).
REQ-002 SHALL have parameter DWELL_WIDTH, default 16, width of dwell_cycles.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, named as follows: clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a sweep, sampled at a clk edge.
REQ-006 stop  input  1  abort the sweep and return to idle.
REQ-007 start_word  input  WORD_WIDTH  first frequency word of the sweep.
REQ-008 stop_word  input  WORD_WIDTH  last frequency word of the sweep.
REQ-009 step_word  input  WORD_WIDTH  increment per step.
REQ-010 dwell_cycles  input  DWELL_WIDTH  clocks each word is held; 0 is treated as 1.
REQ-011 mode  input  2  00 single, 01 sawtooth repeat, 10 triangle, 11 same as 00.
REQ-012 frequency_word  output  WORD_WIDTH  word driven to the NCO.
REQ-013 nco_enable  output  1  enable to the NCO.
REQ-014 busy  output  1  sweep in progress.
REQ-015 step_strobe  output  1  one-cycle pulse in every cycle in which frequency_word takes a new value.
REQ-016 sweep_done  output  1  one-cycle pulse when a single sweep completes.

Function
REQ-017 SHALL implement the states IDLE, UP and DOWN; busy SHALL be 1 exactly in UP and DOWN.
REQ-018 Start acceptance:
- Applies when start=1 and stop=0 at edge N while in IDLE.
- At that edge, start_word, stop_word, step_word, dwell_cycles and mode SHALL be latched.
- From cycle N+1: frequency_word=start_word, nco_enable=1, busy=1, step_strobe=1, state UP.
REQ-019 Configuration inputs SHALL be ignored outside start acceptance; start while busy SHALL be ignored.
REQ-020 A dwell counter SHALL hold each word for exactly max(dwell_cycles,1) cycles; at the end of the dwell the next-word rule applies.
REQ-021 UP next word:
- n = cur + step, computed WORD_WIDTH+1 bits wide.
- If carry=1 or n >= stop_word, the next word SHALL be stop_word (clamp).
REQ-022 DOWN next word:
- n = cur - step.
- If borrow=1 or n <= start_word, the next word SHALL be start_word (clamp).
REQ-023 End of dwell at stop_word while in UP:
- mode 00/11: next edge enters IDLE with sweep_done=1 (one cycle), nco_enable=0, busy=0, frequency_word retained.
- mode 01: next word = start_word, stay UP.
- mode 10: enter DOWN with the next word from REQ-022.
REQ-024 End of dwell at start_word while in DOWN SHALL enter UP with the next word from REQ-021; each endpoint SHALL be dwelt once per pass, never twice.
REQ-025 Degenerate configuration (step_word=0, or start_word >= stop_word):
- frequency_word SHALL stay at start_word.
- mode 00/11: done after one dwell.
- Other modes: hold until stop, with no further step_strobe.
REQ-026 stop=1 at any edge SHALL give, from the next cycle: IDLE, nco_enable=0, busy=0, no sweep_done, frequency_word retained; stop SHALL win over a simultaneous start or sweep completion.
REQ-027 step_strobe and sweep_done SHALL never be asserted in IDLE except the sweep_done cycle of REQ-023.

Reset
REQ-028 rst=1 SHALL immediately, without a clock, force: IDLE, frequency_word=0, nco_enable=0, busy=0, step_strobe=0, sweep_done=0, dwell counter=0, latched configuration=0.
REQ-029 Reset mid-sweep SHALL abort with no sweep_done pulse; after rst deasserts, the block SHALL accept start on the first edge.

Verification
REQ-030 Single sweep:
- Stimulus: start_word=0x100000, stop_word=0x400000, step_word=0x100000, dwell_cycles=3, mode=00, start at edge 0.
- Response: 0x100000 in cycles 1-3, 0x200000 in 4-6, 0x300000 in 7-9, 0x400000 in 10-12; sweep_done=1 and nco_enable=0 in cycle 13; exactly 4 step_strobe pulses.
REQ-031 Clamp and overflow:
- Stimulus A: start_word=0, stop_word=0x250000, step_word=0x100000.
- Response A: 0, 0x100000, 0x200000, 0x250000.
- Stimulus B: start_word=0xC0000000, stop_word=0xFFFFFFFF, step_word=0x80000000.
- Response B: 0xC0000000, then 0xFFFFFFFF (no wrap).
REQ-032 Triangle:
- Stimulus: start_word=0x10, stop_word=0x30, step_word=0x10, dwell_cycles=0, mode=10, running 10 cycles.
- Response: one word per cycle, 10,20,30,20,10,20,30,20,10,20; busy=1 throughout; no sweep_done.
REQ-033 Sawtooth: same words as REQ-032 with mode=01 -> 10,20,30,10,20,30,...
REQ-034 Stop and start collisions:
- stop at cycle 5 of REQ-030 -> cycle 6: nco_enable=0, busy=0, frequency_word=0x200000, no sweep_done.
- start and stop in the same cycle while in IDLE -> remains IDLE.
- start while busy -> no change to the sweep.
REQ-035 Reset and degenerate configuration:
- rst pulse mid-sweep, asynchronous to clk -> all outputs 0 before the next edge.
- step_word=0, mode=00, dwell_cycles=2 -> start_word held 2 cycles, then sweep_done.
